// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the single RegFile write port between two writeback sources.
// Source A is the ALU and source B is the load/store unit. Conflicts are resolved round-robin.
// The RegFile write controls are registered, so a write lands one cycle after it is accepted.
// Optional feature macro: RF_WRITE_BYPASS_EN. When it is defined, the registered write is
// forwarded to read ports A/B so the core does not see the one-cycle write latency.
//
// Handshake (both sources): a transfer happens when x_valid & x_ready are both high in the
// same cycle. x_ready is combinational and depends on x_valid. Until ready is seen, the source
// holds valid, addr and data stable. A source may drop valid before ready to withdraw its
// request, in which case no write happens. At most one transfer occurs per cycle.
module rf_write_arbiter #(
  parameter int WORD_WIDTH        = 16,
  parameter int REG_ADDR_WIDTH    = 3,
  parameter int ZERO_REG_WRITABLE = 0,
  parameter int CNT_WIDTH         = 8
) (
  input  logic                      gclk,
  input  logic                      PowerOn,
  input  logic                      hold,
  input  logic                      a_valid,
  output logic                      a_ready,
  input  logic [REG_ADDR_WIDTH-1:0] a_addr,
  input  logic [WORD_WIDTH-1:0]     a_data,
  input  logic                      b_valid,
  output logic                      b_ready,
  input  logic [REG_ADDR_WIDTH-1:0] b_addr,
  input  logic [WORD_WIDTH-1:0]     b_data,
  output logic                      rf_we,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
  output logic [WORD_WIDTH-1:0]     rf_wdata,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_a,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_b,
  input  logic [WORD_WIDTH-1:0]     rf_rdata_a,
  input  logic [WORD_WIDTH-1:0]     rf_rdata_b,
  output logic [WORD_WIDTH-1:0]     rdata_a,
  output logic [WORD_WIDTH-1:0]     rdata_b,
  output logic [CNT_WIDTH-1:0]      conflicts
);

  // last_grant encoding: 0 = A was granted last, 1 = B was granted last
  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  logic                      last_grant_q, last_grant_d;
  logic                      rf_we_q, rf_we_d;
  logic [REG_ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [WORD_WIDTH-1:0]     rf_wdata_q, rf_wdata_d;
  logic [CNT_WIDTH-1:0]      conflicts_q, conflicts_d;

  logic                      grant_a, grant_b;
  logic                      both_valid;
  logic [REG_ADDR_WIDTH-1:0] sel_addr;
  logic [WORD_WIDTH-1:0]     sel_data;
  logic                      sel_we;

  assign both_valid = a_valid & b_valid;

  // Grant: hold and reset block both sources. A single requester always wins. On a
  // conflict, the source that was not granted last wins.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!PowerOn && !hold) begin
      if (both_valid) begin
        grant_a = (last_grant_q == GRANT_B);
        grant_b = (last_grant_q == GRANT_A);
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // Select the winning write. A write to R0 is accepted but becomes a no-op unless R0 is writable.
  always_comb begin
    sel_addr = grant_b ? b_addr : a_addr;
    sel_data = grant_b ? b_data : a_data;
    sel_we   = (ZERO_REG_WRITABLE != 0) || (sel_addr != '0);
  end

  // Next-state logic for the write registers, the round-robin pointer and the conflict counter
  always_comb begin
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    last_grant_d = last_grant_q;
    conflicts_d  = conflicts_q;
    if (grant_a || grant_b) begin
      rf_we_d      = sel_we;
      rf_waddr_d   = sel_addr;
      rf_wdata_d   = sel_data;
      last_grant_d = grant_b ? GRANT_B : GRANT_A;
    end
    if (!hold && both_valid && (conflicts_q != '1)) begin
      conflicts_d = conflicts_q + 1'b1;
    end
  end

  // State registers. Reset drops any write that is registered but not yet committed.
  always_ff @(posedge gclk) begin
    if (PowerOn) begin
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      last_grant_q <= GRANT_B;
      conflicts_q  <= '0;
    end else begin
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      last_grant_q <= last_grant_d;
      conflicts_q  <= conflicts_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign conflicts = conflicts_q;

`ifdef RF_WRITE_BYPASS_EN
  // Forward the in-flight write to readers of the same register. A write to R0 never
  // matches here when R0 is not writable, because rf_we stays 0 for it.
  always_comb begin
    rdata_a = (rf_we_q && (rf_waddr_q == rd_addr_a)) ? rf_wdata_q : rf_rdata_a;
    rdata_b = (rf_we_q && (rf_waddr_q == rd_addr_b)) ? rf_wdata_q : rf_rdata_b;
  end
`else
  // Pure pass-through. The core stalls one cycle on a read-after-write hazard.
  always_comb begin
    rdata_a = rf_rdata_a;
    rdata_b = rf_rdata_b;
  end

  // The read addresses only matter for bypassing
  logic unused_rd_addr;
  assign unused_rd_addr = ^{rd_addr_a, rd_addr_b};
`endif

endmodule
